// File: rtl/mc_seq_pkg.sv
// Shared types for the multicycle sequencer: FSM states, op codes, opcode field positions.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mc_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        LOAD  = 2'b01,
        EXEC  = 2'b10,
        WRITE = 2'b11
    } state_t;

    typedef enum logic [1:0] {
        MC_MUL = 2'b00,
        MC_DIV = 2'b01,
        MC_SHL = 2'b10,
        MC_SHR = 2'b11
    } op_t;

    // Bit positions of the fields inside mc_opcode: {op, dst, srcA, srcB}
    localparam int OP_MSB   = 7;
    localparam int OP_LSB   = 6;
    localparam int DST_MSB  = 5;
    localparam int DST_LSB  = 4;
    localparam int SRCA_MSB = 3;
    localparam int SRCA_LSB = 2;
    localparam int SRCB_MSB = 1;
    localparam int SRCB_LSB = 0;

endpackage

// File: rtl/mc_step_alu.sv
// Single-iteration datapath: next accumulator/operand values for one MUL, DIV or shift step.
// Latency: purely combinational, no state.
// Backpressure: none; the sequencer decides when a step is committed. DIV step exists only with MC_DIV_EN.
module mc_step_alu
    import mc_seq_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  op_t               op,
    input  logic [DATA_W-1:0] acc,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] acc_nxt,
    output logic [DATA_W-1:0] a_nxt,
    output logic [DATA_W-1:0] b_nxt
);

`ifdef MC_DIV_EN
    logic [DATA_W:0] shifted;
    logic [DATA_W:0] trial;
`endif

    // One step of the selected operation; unused operands pass through unchanged
    always_comb begin
        acc_nxt = acc;
        a_nxt   = a;
        b_nxt   = b;
`ifdef MC_DIV_EN
        // Restoring divide: acc holds the partial remainder, a the dividend/quotient
        shifted = {acc, a[DATA_W-1]};
        trial   = shifted - {1'b0, b};
`endif
        case (op)
            MC_MUL: begin
                // Shift-add: a is the multiplicand moving left, b the multiplier moving right
                if (b[0]) begin
                    acc_nxt = acc + a;
                end
                a_nxt = a << 1;
                b_nxt = b >> 1;
            end
`ifdef MC_DIV_EN
            MC_DIV: begin
                // Remainder stays below the divisor, so it always fits in DATA_W bits
                if (!trial[DATA_W]) begin
                    acc_nxt = trial[DATA_W-1:0];
                    a_nxt   = {a[DATA_W-2:0], 1'b1};
                end else begin
                    acc_nxt = shifted[DATA_W-1:0];
                    a_nxt   = {a[DATA_W-2:0], 1'b0};
                end
            end
`endif
            MC_SHL: a_nxt = a << 1;
            MC_SHR: a_nxt = a >> 1;
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_sequencer.sv
// Multicycle executor: iterative MUL, restoring DIV (MC_DIV_EN) and multi-bit shifts into the register file.
// Latency: accept->done is 2+DATA_W cycles for MUL/DIV, 2+n for a shift by n, 2 for DIV by zero or unsupported DIV.
// Backpressure: stall holds fetch while busy; requests arriving while busy (including WRITE) are dropped.
module multicycle_sequencer
    import mc_seq_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mc_valid,
    input  logic [7:0]        mc_opcode,
    output logic [1:0]        rf_rd_sel_a,
    output logic [1:0]        rf_rd_sel_b,
    input  logic [DATA_W-1:0] rf_rd_data_a,
    input  logic [DATA_W-1:0] rf_rd_data_b,
    output logic              rf_wr_en,
    output logic [1:0]        rf_wr_sel,
    output logic [DATA_W-1:0] rf_wr_data,
    output logic              stall,
    output logic              busy,
    output logic              done,
    output logic              div_zero
);

    state_t            state_q, state_d;
    logic [7:0]        opcode_q, opcode_d;
    logic [DATA_W-1:0] opa_q, opa_d;
    logic [DATA_W-1:0] opb_q, opb_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              div_zero_q, div_zero_d;

    op_t               op;
    logic [DATA_W-1:0] alu_acc, alu_a, alu_b;

    assign op = op_t'(opcode_q[OP_MSB:OP_LSB]);

    mc_step_alu #(
        .DATA_W (DATA_W)
    ) u_step_alu (
        .op      (op),
        .acc     (acc_q),
        .a       (opa_q),
        .b       (opb_q),
        .acc_nxt (alu_acc),
        .a_nxt   (alu_a),
        .b_nxt   (alu_b)
    );

    // Next-state logic: accept, load operands and step count, iterate, write back
    always_comb begin
        state_d    = state_q;
        opcode_d   = opcode_q;
        opa_d      = opa_q;
        opb_d      = opb_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        div_zero_d = div_zero_q;
        case (state_q)
            IDLE: begin
                if (mc_valid) begin
                    opcode_d   = mc_opcode;
                    div_zero_d = 1'b0;
                    state_d    = LOAD;
                end
            end
            LOAD: begin
                opa_d = rf_rd_data_a;
                opb_d = rf_rd_data_b;
                acc_d = '0;
                case (op)
                    MC_MUL: begin
                        cnt_d   = CNT_W'(DATA_W);
                        state_d = EXEC;
                    end
                    MC_DIV: begin
`ifdef MC_DIV_EN
                        if (rf_rd_data_b == '0) begin
                            // Divide by zero: saturate the quotient and flag it
                            opa_d      = '1;
                            div_zero_d = 1'b1;
                            cnt_d      = '0;
                            state_d    = WRITE;
                        end else begin
                            cnt_d   = CNT_W'(DATA_W);
                            state_d = EXEC;
                        end
`else
                        // No divider: write zero and flag the op as unsupported
                        opa_d      = '0;
                        div_zero_d = 1'b1;
                        cnt_d      = '0;
                        state_d    = WRITE;
`endif
                    end
                    default: begin
                        // Shifts take one step per bit; a zero count writes opA back untouched
                        cnt_d   = CNT_W'(rf_rd_data_b[2:0]);
                        state_d = (rf_rd_data_b[2:0] == 3'd0) ? WRITE : EXEC;
                    end
                endcase
            end
            EXEC: begin
                acc_d = alu_acc;
                opa_d = alu_a;
                opb_d = alu_b;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = WRITE;
                end
            end
            WRITE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            opcode_q   <= '0;
            opa_q      <= '0;
            opb_q      <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            opcode_q   <= opcode_d;
            opa_q      <= opa_d;
            opb_q      <= opb_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            div_zero_q <= div_zero_d;
        end
    end

    // Register-file interface and status, decoded from the current state
    always_comb begin
        rf_rd_sel_a = '0;
        rf_rd_sel_b = '0;
        rf_wr_en    = 1'b0;
        rf_wr_sel   = '0;
        rf_wr_data  = '0;
        if (state_q == LOAD) begin
            rf_rd_sel_a = opcode_q[SRCA_MSB:SRCA_LSB];
            rf_rd_sel_b = opcode_q[SRCB_MSB:SRCB_LSB];
        end
        if (state_q == WRITE) begin
            rf_wr_en   = 1'b1;
            rf_wr_sel  = opcode_q[DST_MSB:DST_LSB];
            rf_wr_data = (op == MC_MUL) ? acc_q : opa_q;
        end
    end

    assign busy     = (state_q != IDLE);
    assign stall    = (mc_valid && (state_q == IDLE)) || (state_q != IDLE);
    assign done     = rf_wr_en;
    assign div_zero = div_zero_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Bench for multicycle_sequencer: behavioural register-file model plus cycle-by-cycle output checks.
// Latency: expected per-op timing derived from operation rules, not from the FSM.
// Backpressure: random mc_valid noise while busy must be ignored; MC_DIV_EN selects DIV expectations.
module tb_multicycle_sequencer;

    logic       clk;
    logic       reset;
    logic       mc_valid;
    logic [7:0] mc_opcode;
    logic [1:0] rf_rd_sel_a, rf_rd_sel_b;
    logic [7:0] rf_rd_data_a, rf_rd_data_b;
    logic       rf_wr_en;
    logic [1:0] rf_wr_sel;
    logic [7:0] rf_wr_data;
    logic       stall, busy, done, div_zero;

    logic [3:0][7:0] mem;
    logic [3:0][7:0] pre_v;
    logic            preload;
    logic [3:0][7:0] mdl_regs;
    bit              mdl_dz;

    int checks = 0;
    int errors = 0;
    int wr_count = 0;
    int exp_writes = 0;

    multicycle_sequencer #(.DATA_W(8), .CNT_W(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .mc_valid     (mc_valid),
        .mc_opcode    (mc_opcode),
        .rf_rd_sel_a  (rf_rd_sel_a),
        .rf_rd_sel_b  (rf_rd_sel_b),
        .rf_rd_data_a (rf_rd_data_a),
        .rf_rd_data_b (rf_rd_data_b),
        .rf_wr_en     (rf_wr_en),
        .rf_wr_sel    (rf_wr_sel),
        .rf_wr_data   (rf_wr_data),
        .stall        (stall),
        .busy         (busy),
        .done         (done),
        .div_zero     (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file seen by the DUT: combinational read, clocked write or bench preload
    assign rf_rd_data_a = mem[rf_rd_sel_a];
    assign rf_rd_data_b = mem[rf_rd_sel_b];
    always @(posedge clk) begin
        if (preload) mem <= pre_v;
        else if (rf_wr_en) mem[rf_wr_sel] <= rf_wr_data;
    end

    always @(negedge clk) if (rf_wr_en === 1'b1) wr_count++;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference behaviour of one operation: result, accept->done cycles, div_zero flag
    function automatic void model(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                                  output logic [7:0] r, output int lat, output bit dz);
        int p;
        dz = 0;
        case (op)
            2'd0: begin p = int'(a) * int'(b); r = p[7:0]; lat = 10; end
`ifdef MC_DIV_EN
            2'd1: begin
                if (b == 0) begin r = 8'hFF; lat = 2; dz = 1; end
                else begin r = a / b; lat = 10; end
            end
`else
            2'd1: begin r = 8'h00; lat = 2; dz = 1; end
`endif
            2'd2: begin r = a << b[2:0]; lat = 2 + int'(b[2:0]); end
            default: begin r = a >> b[2:0]; lat = 2 + int'(b[2:0]); end
        endcase
    endfunction

    task automatic load_regs(input logic [3:0][7:0] v);
        pre_v = v;
        preload = 1'b1;
        @(posedge clk);
        #1 preload = 1'b0;
        mdl_regs = v;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            #1;
            check("idle_busy", busy, 0);
            check("idle_stall", stall, 0);
            check("idle_done", done, 0);
            check("idle_dz", div_zero, mdl_dz);
        end
    endtask

    // Issue one request in the current (idle) cycle and check every cycle through the write
    task automatic do_op(input logic [7:0] opc, input bit hold, input bit noise,
                         output logic [7:0] got, output int got_cyc);
        logic [7:0] er;
        int lat;
        bit dz;
        model(opc[7:6], mdl_regs[opc[3:2]], mdl_regs[opc[1:0]], er, lat, dz);
        got = '0;
        got_cyc = -1;
        mc_valid = 1'b1;
        mc_opcode = opc;
        #1;
        check("acc_busy", busy, 0);
        check("acc_stall", stall, 1);
        check("acc_dz", div_zero, mdl_dz);
        for (int c = 1; c <= lat + 1; c++) begin
            @(negedge clk);
            if (c <= lat && noise) begin
                mc_valid = 1'($urandom_range(0, 1));
                mc_opcode = 8'($urandom);
            end else begin
                mc_valid = hold;
                mc_opcode = opc;
            end
            #1;
            if (done === 1'b1) begin
                got = rf_wr_data;
                if (got_cyc < 0) got_cyc = c;
            end
            check("done", done, c == lat);
            check("wr_en", rf_wr_en, c == lat);
            check("busy", busy, c <= lat);
            check("stall", stall, (c <= lat) || hold);
            check("div_zero", div_zero, (c == 1) ? 1'b0 : dz);
            if (c == 1) begin
                check("rd_sel_a", rf_rd_sel_a, opc[3:2]);
                check("rd_sel_b", rf_rd_sel_b, opc[1:0]);
            end
            if (c == lat) begin
                check("wr_sel", rf_wr_sel, opc[5:4]);
                check("wr_data", rf_wr_data, er);
            end
        end
        mdl_regs[opc[5:4]] = er;
        mdl_dz = dz;
        exp_writes++;
    endtask

    initial begin
        logic [7:0] r, r2;
        int cy, cy2, wc;
        logic [7:0] pr;
        int plat;
        bit pdz;
        logic [3:0][7:0] v;
        logic [7:0] opc;

        reset = 1'b1;
        mc_valid = 1'b0;
        mc_opcode = '0;
        preload = 1'b0;
        pre_v = '0;
        mdl_regs = '0;
        mdl_dz = 0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_stall", stall, 0);
        check("rst_done", done, 0);
        check("rst_wr_en", rf_wr_en, 0);
        check("rst_wr_sel", rf_wr_sel, 0);
        check("rst_wr_data", rf_wr_data, 0);
        check("rst_dz", div_zero, 0);
        check("rst_rd_sel", {rf_rd_sel_a, rf_rd_sel_b}, 0);
        reset = 1'b0;
        @(negedge clk);

        // Hand-computed values that pin the model
        model(2'd0, 8'd13, 8'd11, pr, plat, pdz);
        check("pin_mul_r", pr, 143);
        check("pin_mul_lat", plat, 10);
        model(2'd2, 8'h81, 8'd3, pr, plat, pdz);
        check("pin_shl_r", pr, 8'h08);
        check("pin_shl_lat", plat, 5);

        // MUL 13*11 -> r2
        load_regs({8'd0, 8'd0, 8'd11, 8'd13});
        do_op(8'h21, 0, 0, r, cy);
        check("mul13x11_data", r, 143);
        check("mul13x11_cyc", cy, 10);
        idle(1);

        // MUL 200*3 wraps mod 256
        load_regs({8'd0, 8'd0, 8'd3, 8'd200});
        do_op(8'h21, 0, 0, r, cy);
        check("mul200x3_data", r, 8'h58);

        // DIV 100/7 -> r3
        load_regs({8'd0, 8'd0, 8'd7, 8'd100});
        do_op(8'h71, 0, 0, r, cy);
`ifdef MC_DIV_EN
        check("div100_7_data", r, 14);
        check("div100_7_cyc", cy, 10);
        check("div100_7_dz", div_zero, 0);
`else
        check("div_unsup_data", r, 0);
        check("div_unsup_cyc", cy, 2);
        check("div_unsup_dz", div_zero, 1);
`endif

        // DIV 5/0
        load_regs({8'd0, 8'd0, 8'd0, 8'd5});
        do_op(8'h71, 0, 0, r, cy);
`ifdef MC_DIV_EN
        check("div5_0_data", r, 8'hFF);
`else
        check("div5_0_data", r, 8'h00);
`endif
        check("div5_0_cyc", cy, 2);
        check("div5_0_dz", div_zero, 1);

        // SHL 0x81 by 3, SHR by 0 (also clears div_zero)
        load_regs({8'd0, 8'd0, 8'd3, 8'h81});
        do_op(8'hA1, 0, 0, r, cy);
        check("shl_data", r, 8'h08);
        check("shl_cyc", cy, 5);
        load_regs({8'd0, 8'd0, 8'd0, 8'h81});
        do_op(8'hE1, 0, 0, r, cy);
        check("shr0_data", r, 8'h81);
        check("shr0_cyc", cy, 2);
        check("shr0_dz", div_zero, 0);

        // mc_valid held high through a MUL: one write, next request only after IDLE
        load_regs({8'd0, 8'd0, 8'd11, 8'd13});
        wc = wr_count;
        do_op(8'h21, 1, 0, r, cy);
        check("hold_writes_1", wr_count - wc, 1);
        do_op(8'h21, 0, 0, r2, cy2);
        check("hold_writes_2", wr_count - wc, 2);
        check("hold_second_data", r2, 143);

        // Reset during EXEC cycle 4: no write, clean afterwards
        load_regs({8'd0, 8'd0, 8'd3, 8'd200});
        wc = wr_count;
        mc_valid = 1'b1;
        mc_opcode = 8'h21;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            mc_valid = 1'b0;
            if (c == 4) reset = 1'b1;
            #1;
            check("prerst_busy", busy, 1);
        end
        @(negedge clk);
        #1;
        check("postrst_busy", busy, 0);
        check("postrst_stall", stall, 0);
        check("postrst_done", done, 0);
        check("postrst_wr_en", rf_wr_en, 0);
        check("postrst_nowrite", wr_count - wc, 0);
        reset = 1'b0;
        mdl_dz = 0;
        idle(1);
        do_op(8'h21, 0, 0, r, cy);
        check("postrst_mul", r, 8'h58);
        check("postrst_cyc", cy, 10);

        // Randomized operations with noise on mc_valid/mc_opcode while busy
        for (int n = 0; n < 40; n++) begin
            opc = 8'($urandom);
            for (int i = 0; i < 4; i++) v[i] = 8'($urandom);
            if ($urandom_range(0, 3) == 0) v[opc[1:0]] = 8'h00;
            load_regs(v);
            do_op(opc, 0, 1, r, cy);
            idle($urandom_range(0, 2));
        end

        idle(1);
        check("write_count", wr_count, exp_writes);
        for (int i = 0; i < 4; i++) check("final_reg", mem[i], mdl_regs[i]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
